// File: rtl/gen_mux_pkg.sv
// Shared constants and helpers for the handshaked channel selector.
package gen_mux_pkg;
    localparam int MODE_DIRECT = 0;
    localparam int MODE_RR     = 1;

    function automatic int ch_num(input int sel);
        return 1 << sel;
    endfunction
endpackage

// File: rtl/gen_mux_stream_rr_arbiter.sv
// Round-robin priority search starting one above the pointer, wrapping modulo CH_NUM.
// Combinational, zero latency; no backpressure of its own.
module rr_arbiter
    import gen_mux_pkg::*;
#(
    parameter int SEL = 5
) (
    input  logic [ch_num(SEL)-1:0] req,
    input  logic [SEL-1:0]         ptr,
    output logic [SEL-1:0]         grant,
    output logic                   any_req
);
    localparam int CH_NUM = ch_num(SEL);

    logic [SEL-1:0] idx;
    logic           found;

    // Offset CH_NUM truncates to the pointer itself, so a lone requester at ptr still wins.
    always_comb begin
        grant   = '0;
        idx     = '0;
        found   = 1'b0;
        any_req = |req;
        for (int i = 1; i <= CH_NUM; i++) begin
            idx = ptr + SEL'(i);
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/gen_mux_stream.sv
// Selects one of 2**SEL channels (direct or round-robin) into a single valid/ready output register.
// Latency 1 cycle accept-to-valid_out; full throughput with pop and load in the same cycle.
// Backpressure: ready_out is zero while the output is full and ready_in is low. Optional parity: GEN_MUX_STREAM_PARITY_EN.
module gen_mux_stream
    import gen_mux_pkg::*;
#(
    parameter int BUS_WIDTH = 4,
    parameter int SEL       = 5,
    parameter int RR_MODE   = MODE_DIRECT
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [BUS_WIDTH*ch_num(SEL)-1:0] data_in,
    input  logic [ch_num(SEL)-1:0]           valid_in,
    output logic [ch_num(SEL)-1:0]           ready_out,
    input  logic [SEL-1:0]                   ctrl_sel,
    output logic [BUS_WIDTH-1:0]             data_out,
    output logic                             valid_out,
    input  logic                             ready_in,
    output logic [SEL-1:0]                   grant_sel
`ifdef GEN_MUX_STREAM_PARITY_EN
    ,
    output logic                             parity_out
`endif
);
    localparam int CH_NUM = ch_num(SEL);

    logic [SEL-1:0]       cand;
    logic                 req;
    logic                 can_load;
    logic                 load;
    logic [BUS_WIDTH-1:0] word;

    logic                 valid_q, valid_d;
    logic [BUS_WIDTH-1:0] data_q, data_d;
    logic [SEL-1:0]       grant_q, grant_d;

    generate
        if (RR_MODE == MODE_RR) begin : g_rr
            logic [SEL-1:0] ptr_q, ptr_d;
            logic           unused_ctrl_sel;

            assign unused_ctrl_sel = ^ctrl_sel;

            rr_arbiter #(.SEL(SEL)) u_arb (
                .req     (valid_in),
                .ptr     (ptr_q),
                .grant   (cand),
                .any_req (req)
            );

            always_comb begin
                ptr_d = ptr_q;
                if (load) ptr_d = cand;
            end

            // Pointer resets to the top channel so channel 0 is searched first.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) ptr_q <= SEL'(CH_NUM - 1);
                else        ptr_q <= ptr_d;
            end
        end else begin : g_direct
            assign cand = ctrl_sel;
            assign req  = valid_in[ctrl_sel];
        end
    endgenerate

    assign can_load = !valid_q || ready_in;
    assign load     = can_load && req;
    assign word     = data_in[int'(cand)*BUS_WIDTH +: BUS_WIDTH];

    // State register: valid_q is the EMPTY/FULL state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            grant_q <= grant_d;
        end
    end

    // Next state: a load takes priority over a bare pop.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        grant_d = grant_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = word;
            grant_d = cand;
        end else if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end
    end

    // Outputs; rst_n gates the combinational accept so nothing is taken during reset.
    always_comb begin
        ready_out = '0;
        if (load && rst_n) ready_out[cand] = 1'b1;
        data_out  = data_q;
        valid_out = valid_q;
        grant_sel = grant_q;
    end

`ifdef GEN_MUX_STREAM_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (load) parity_d = ^word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity_q <= 1'b0;
        else        parity_q <= parity_d;
    end

    assign parity_out = parity_q;
`endif
endmodule

// File: doc/gen_mux_stream.md
Name: gen_mux_stream

Overview:
Registered, handshaked successor to the combinational bus selector. It chooses one of 2**SEL input channels, each BUS_WIDTH bits wide. Selection is either direct, by ctrl_sel, or by a round-robin arbiter over the channels that are requesting. The chosen word is passed through a single valid/ready output register. The block sits between multiple producer FSMs (frame/CCC/data paths) and one shared downstream consumer (serializer/TX path).

Parameters:
BUS_WIDTH, 4, width of each channel word
SEL, 5, select width; channel count CH_NUM = 2**SEL
RR_MODE, 0, 0 = direct select by ctrl_sel; 1 = round-robin arbitration (ctrl_sel ignored)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
data_in  input  BUS_WIDTH*CH_NUM  packed channel words; channel k at [k*BUS_WIDTH +: BUS_WIDTH]
valid_in  input  CH_NUM  per-channel word-valid
ready_out  output  CH_NUM  per-channel accept; one-hot or zero; combinational
ctrl_sel  input  SEL  channel select (RR_MODE=0 only)
data_out  output  BUS_WIDTH  registered selected word
valid_out  output  1  data_out holds an unconsumed word
ready_in  input  1  downstream accepts data_out this cycle
grant_sel  output  SEL  registered index of the channel that produced data_out

Behaviour:
- Reset is asynchronous and active-low. Reset values: data_out=0, valid_out=0, grant_sel=0, RR pointer=CH_NUM-1, so channel 0 has first priority. ready_out is 0 during reset.
- Output stage is a 2-state FSM encoded by valid_out. EMPTY (valid_out=0) and FULL (valid_out=1).
- Define can_load = !valid_out || ready_in. Full throughput: pop and load in the same cycle.
- Candidate selection:
  - RR_MODE=0: cand = ctrl_sel; req = valid_in[ctrl_sel].
  - RR_MODE=1: search valid_in from pointer+1 upward, wrapping modulo CH_NUM. cand = first set bit; req = |valid_in.
- ready_out[cand] = can_load && req. All other bits are 0.
- Transfer on channel cand occurs when ready_out[cand]=1. On the next edge: data_out <= word[cand], grant_sel <= cand, valid_out <= 1. In RR mode, pointer <= cand.
- If FULL && ready_in && !req: valid_out <= 0. data_out and grant_sel hold their last values.
- If FULL && !ready_in: data_out, grant_sel, valid_out and the pointer all hold. ready_out=0. ctrl_sel or valid_in changes have no effect.
- Latency is 1 cycle from accept to valid_out.
- Round-robin wrap: pointer=CH_NUM-1 searches from 0. A sole requester equal to the pointer is still granted, because the search covers all CH_NUM positions.
- Direct mode: a request on an unselected channel is never accepted and is not counted.
- Reset mid-transfer: the held word is discarded and outputs return to their reset values immediately (asynchronous).
- Index arithmetic is SEL bits, modulo CH_NUM. There is no out-of-range select.

Optional Feature:
Macro GEN_MUX_STREAM_PARITY_EN.
- Defined: adds output parity_out (1 bit, registered with data_out, reset 0) = ^word[cand], even parity.
- Not defined: port absent, no parity logic.

Decomposition:
- Package gen_mux_pkg:
  - localparam function ch_num(SEL) = 2**SEL
  - mode constants MODE_DIRECT=0, MODE_RR=1
- Sub-module rr_arbiter: combinational priority search from pointer+1 with wrap. Inputs are req vector [CH_NUM] and pointer [SEL]. Outputs are grant index [SEL] and any_req. Instantiated only under RR_MODE=1 via a generate branch.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with valid_out=1 -> data_out=0, valid_out=0, grant_sel=0 immediately; ready_out=0.
- Direct, SEL=2, BUS_WIDTH=4, data_in=16'hDCBA, ctrl_sel=2, valid_in=4'b0100, ready_in=1 -> ready_out=4'b0100; next cycle data_out=4'hC, grant_sel=2, valid_out=1.
- Backpressure: FULL with data_out=4'hC, ready_in=0 for 3 cycles, ctrl_sel changed to 1 -> data_out stays 4'hC, ready_out=0; ready_in=1 -> channel 1 loaded (4'hB) the same cycle as the pop.
- RR fairness: RR_MODE=1, valid_in=4'b1111 held, ready_in=1 -> grant_sel sequence 0,1,2,3,0, one word per cycle.
- RR wrap and skip: pointer=3, valid_in=4'b1000 -> grant 3; then valid_in=4'b0101 -> grant 0, then 2.
- Parity (macro defined): granted word 4'b1011 -> parity_out=1; word 4'b0110 -> parity_out=0.
